// File: rtl/raifes_hasti_mem_arbiter_pkg.sv
// Shared constants and types for the two-master HASTI SRAM arbiter.
// HTRANS/HRESP encodings plus the data-phase owner encoding.
package raifes_hasti_mem_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Which master, if any, owns the slave data phase currently in flight.
  typedef enum logic [1:0] {
    DPH_NONE = 2'd0,
    DPH_M0   = 2'd1,
    DPH_M1   = 2'd2
  } dph_e;

endpackage

// File: rtl/raifes_hasti_mem_arbiter_if.sv
// One HASTI (AHB-Lite) bus segment. The master modport is the side that
// drives address/write data; the slave modport answers with ready/resp/rdata.
interface raifes_hasti_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [1:0]        htrans;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    output haddr, hwrite, hsize, htrans, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hwrite, hsize, htrans, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/raifes_arb_pend_reg.sv
// Per-master buffer for an address phase that lost arbitration (or arrived
// while the slave was stalled). Capture wins over clear; both are strobes.
module raifes_arb_pend_reg #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic              clear,
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  input  logic [2:0]        size,
  output logic              valid,
  output logic [ADDR_W-1:0] q_addr,
  output logic              q_write,
  output logic [2:0]        q_size
);

  // Valid flag: set on capture, dropped once the buffered phase is replayed.
  always_ff @(posedge clk) begin
    if (reset)        valid <= 1'b0;
    else if (capture) valid <= 1'b1;
    else if (clear)   valid <= 1'b0;
  end

  // Payload only moves on capture; it is meaningless while valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_addr  <= '0;
      q_write <= 1'b0;
      q_size  <= 3'd0;
    end else if (capture) begin
      q_addr  <= addr;
      q_write <= write;
      q_size  <= size;
    end
  end

endmodule

// File: rtl/raifes_hasti_mem_arbiter.sv
// Two-master HASTI arbiter in front of one SRAM slave (m0 = imem, m1 = dmem).
// Losing address phases are parked in a pend reg and replayed; the parked
// master sees hready low until its transfer finishes.
// Optional round-robin tie break: define RAIFES_ARB_RR_EN.
module raifes_hasti_mem_arbiter
  import raifes_hasti_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int PRIO_M = 1
) (
  input  logic clk,
  input  logic reset,
  raifes_hasti_mem_arbiter_if.slave  m0,
  raifes_hasti_mem_arbiter_if.slave  m1,
  raifes_hasti_mem_arbiter_if.master s
);

  localparam int   NM       = 2;
  localparam logic PRIO_BIT = (PRIO_M != 0);

  logic [NM-1:0][ADDR_W-1:0] in_addr, pend_addr;
  logic [NM-1:0][2:0]        in_size, pend_size;
  logic [NM-1:0]             in_write, pend_write, in_req;
  logic [NM-1:0]             pend, live, cand, grant, capture, own, hready, hresp;
  logic                      issue, win, tie_win;
  logic [ADDR_W-1:0]         bus_addr;
  logic [2:0]                bus_size;
  logic                      bus_write;
  logic [1:0]                bus_trans;
  logic [DATA_W-1:0]         wdata_sel;
  logic                      unused_busy;
  dph_e                      dph, dph_nxt;

  assign in_addr  = {m1.haddr,  m0.haddr};
  assign in_size  = {m1.hsize,  m0.hsize};
  assign in_write = {m1.hwrite, m0.hwrite};
  // Only htrans[1] matters: IDLE and BUSY are never forwarded.
  assign in_req      = {m1.htrans[1], m0.htrans[1]};
  assign unused_busy = m0.htrans[0] ^ m1.htrans[0];

  for (genvar i = 0; i < NM; i++) begin : g_pend
    raifes_arb_pend_reg #(.ADDR_W(ADDR_W)) u_pend (
      .clk     (clk),
      .reset   (reset),
      .capture (capture[i]),
      .clear   (grant[i]),
      .addr    (in_addr[i]),
      .write   (in_write[i]),
      .size    (in_size[i]),
      .valid   (pend[i]),
      .q_addr  (pend_addr[i]),
      .q_write (pend_write[i]),
      .q_size  (pend_size[i])
    );
  end

  // A live request is one the master believes was accepted this cycle.
  assign live    = in_req & hready;
  assign cand    = pend | live;
  assign issue   = ~reset & s.hready & (|cand);
  assign grant   = issue ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign capture = live & ~grant;

`ifdef RAIFES_ARB_RR_EN
  logic last_grant, tie_seen;

  // Round-robin history; PRIO_M breaks only the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b0;
      tie_seen   <= 1'b0;
    end else if (issue) begin
      last_grant <= win;
      if (&cand) tie_seen <= 1'b1;
    end
  end

  assign tie_win = tie_seen ? ~last_grant : PRIO_BIT;
`else
  assign tie_win = PRIO_BIT;
`endif

  // Winner select: a sole candidate wins outright, otherwise the tie rule.
  always_comb begin
    win = tie_win;
    case (cand)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = tie_win;
    endcase
  end

  // Data-phase owner register.
  always_ff @(posedge clk) begin
    if (reset) dph <= DPH_NONE;
    else       dph <= dph_nxt;
  end

  // Owner advances only when the slave finishes the current data phase.
  always_comb begin
    dph_nxt = dph;
    if (s.hready) dph_nxt = issue ? (win ? DPH_M1 : DPH_M0) : DPH_NONE;
  end

  assign own = {dph == DPH_M1, dph == DPH_M0};

  // Owner sees the slave's ready/resp; a parked master is held off; others idle-ready.
  always_comb begin
    hready = '1;
    hresp  = {NM{HRESP_OKAY}};
    if (!reset) begin
      for (int i = 0; i < NM; i++) begin
        hready[i] = own[i] ? s.hready : ~pend[i];
        hresp[i]  = own[i] ? s.hresp  : HRESP_OKAY;
      end
    end
  end

  // Address phase toward the slave; a parked phase takes precedence over live inputs.
  always_comb begin
    bus_trans = HTRANS_IDLE;
    bus_addr  = '0;
    bus_write = 1'b0;
    bus_size  = 3'd0;
    if (issue) begin
      bus_trans = HTRANS_NONSEQ;
      if (pend[win]) begin
        bus_addr  = pend_addr[win];
        bus_write = pend_write[win];
        bus_size  = pend_size[win];
      end else begin
        bus_addr  = in_addr[win];
        bus_write = in_write[win];
        bus_size  = in_size[win];
      end
    end
  end

  assign wdata_sel = (dph == DPH_M1) ? m1.hwdata : m0.hwdata;

  assign s.htrans  = bus_trans;
  assign s.haddr   = bus_addr;
  assign s.hwrite  = bus_write;
  assign s.hsize   = bus_size;
  assign s.hwdata  = wdata_sel;

  assign m0.hready = hready[0];
  assign m1.hready = hready[1];
  assign m0.hresp  = hresp[0];
  assign m1.hresp  = hresp[1];
  assign m0.hrdata = s.hrdata;
  assign m1.hrdata = s.hrdata;

endmodule
